// File: rtl/alu_issue_ctrl_if.sv
// Request/ALU/response bundle for alu_issue_ctrl.
// slave = controller side, master = sequencer/ALU/testbench side.
interface alu_issue_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              i_req_valid;
  logic              o_req_ready;
  logic [1:0]        i_req_op;
  logic [DATA_W-1:0] i_req_a;
  logic [DATA_W-1:0] i_req_b;
  logic [DATA_W-1:0] o_alu_in1;
  logic [DATA_W-1:0] o_alu_in2;
  logic [1:0]        o_alu_op;
  logic [DATA_W-1:0] i_alu_out;
  logic              i_alu_z;
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [DATA_W-1:0] o_rsp_data;
  logic              o_rsp_z;
  logic              o_busy;

  modport slave (
    input  i_req_valid, i_req_op, i_req_a, i_req_b,
    input  i_alu_out, i_alu_z, i_rsp_ready,
    output o_req_ready, o_alu_in1, o_alu_in2, o_alu_op,
    output o_rsp_valid, o_rsp_data, o_rsp_z, o_busy
  );

  modport master (
    output i_req_valid, i_req_op, i_req_a, i_req_b,
    output i_alu_out, i_alu_z, i_rsp_ready,
    input  o_req_ready, o_alu_in1, o_alu_in2, o_alu_op,
    input  o_rsp_valid, o_rsp_data, o_rsp_z, o_busy
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one op to the registered ALU, waits out result/zero-flag latency, returns it.
// Ports: i_clk, i_rst (async high), bus (req handshake, ALU drive, rsp handshake).
module alu_issue_ctrl #(
  parameter int DATA_W = 16
) (
  input logic i_clk,
  input logic i_rst,
  alu_issue_ctrl_if.slave bus
);
  localparam logic [1:0] OP_READ = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SUB  = 2'd2;
  localparam logic [1:0] OP_MUL  = 2'd3;

  typedef enum logic [2:0] {
    IDLE, ISSUE, SETTLE, CAPTURE, RESP
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] in1_q, in1_d;
  logic [DATA_W-1:0] in2_q, in2_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              z_q, z_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    op_d    = OP_READ;
    data_d  = data_q;
    z_d     = z_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_req_valid && ready_q) begin
          state_d = ISSUE;
          op_d    = bus.i_req_op;
          // ALU computes in2 - in1, so SUB swaps to yield A - B
          unique case (1'b1)
            bus.i_req_op == OP_READ: begin
              in1_d = '0;
              in2_d = '0;
            end
            bus.i_req_op == OP_SUB: begin
              in1_d = bus.i_req_b;
              in2_d = bus.i_req_a;
            end
            bus.i_req_op == OP_ADD,
            bus.i_req_op == OP_MUL: begin
              in1_d = bus.i_req_a;
              in2_d = bus.i_req_b;
            end
            default: ;
          endcase
        end
      end
      ISSUE:   state_d = SETTLE;
      SETTLE:  state_d = CAPTURE;
      CAPTURE: begin
        // zero flag lags the result by one edge; both valid here
        data_d  = bus.i_alu_out;
        z_d     = bus.i_alu_z;
        state_d = RESP;
      end
      RESP: begin
        if (bus.i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == RESP);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      in1_q   <= '0;
      in2_q   <= '0;
      op_q    <= OP_READ;
      data_q  <= '0;
      z_q     <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      op_q    <= op_d;
      data_q  <= data_d;
      z_q     <= z_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_alu_in1   = in1_q;
  assign bus.o_alu_in2   = in2_q;
  assign bus.o_alu_op    = op_q;
  assign bus.o_rsp_data  = data_q;
  assign bus.o_rsp_z     = z_q;
  assign bus.o_req_ready = ready_q;
  assign bus.o_rsp_valid = valid_q;
  assign bus.o_busy      = busy_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a behavioural registered ALU.
// Expected responses queued at request time, compared at response handshake.
module tb_alu_issue_ctrl;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [16:0] sb_q[$];
  logic [15:0] held = 16'h0;

  alu_issue_ctrl_if #(.DATA_W(W)) bus();

  alu_issue_ctrl #(.DATA_W(W)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: result registered on op, zero flag one edge later.
  logic [15:0] alu_q = 16'h0;
  logic        alu_z_q = 1'b1;
  always @(posedge clk) begin
    case (bus.o_alu_op)
      2'd1: alu_q <= bus.o_alu_in1 + bus.o_alu_in2;
      2'd2: alu_q <= bus.o_alu_in2 - bus.o_alu_in1;
      2'd3: alu_q <= bus.o_alu_in1 * bus.o_alu_in2;
      default: ;
    endcase
    alu_z_q <= (alu_q == 16'h0);
  end
  assign bus.i_alu_out = alu_q;
  assign bus.i_alu_z   = alu_z_q;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon
    logic [16:0] e;
    if (!rst && bus.o_rsp_valid && bus.i_rsp_ready) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_data", bus.o_rsp_data, e[15:0]);
        chk("rsp_z", bus.o_rsp_z, e[16]);
      end
    end
  end

  task automatic check_reset_vals(string tag);
    chk({tag, "_ready"}, bus.o_req_ready, 1);
    chk({tag, "_valid"}, bus.o_rsp_valid, 0);
    chk({tag, "_busy"}, bus.o_busy, 0);
    chk({tag, "_data"}, bus.o_rsp_data, 0);
    chk({tag, "_z"}, bus.o_rsp_z, 0);
    chk({tag, "_in1"}, bus.o_alu_in1, 0);
    chk({tag, "_in2"}, bus.o_alu_in2, 0);
    chk({tag, "_op"}, bus.o_alu_op, 0);
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!bus.o_req_ready && t < 20) begin
      step();
      t++;
    end
    chk("req_ready_timeout", t < 20, 1);
  endtask

  task automatic run_op(
    input logic [1:0]  op,
    input logic [15:0] a,
    input logic [15:0] b,
    input int          stall,
    input logic [1:0]  nop,
    input logic [15:0] na,
    input logic [15:0] nb
  );
    logic [15:0] r, m1, m2, sd;
    logic        sz;
    case (op)
      2'd0: r = held;
      2'd1: r = a + b;
      2'd2: r = a - b;
      default: r = a * b;
    endcase
    if (op != 2'd0) held = r;
    m1 = (op == 2'd0) ? 16'h0 : (op == 2'd2) ? b : a;
    m2 = (op == 2'd0) ? 16'h0 : (op == 2'd2) ? a : b;
    bus.i_req_valid = 1'b1;
    bus.i_req_op    = op;
    bus.i_req_a     = a;
    bus.i_req_b     = b;
    wait_ready();
    sb_q.push_back({r == 16'h0, r});
    step();
    bus.i_req_valid = 1'b0;
    chk("issue_op", bus.o_alu_op, op);
    chk("issue_in1", bus.o_alu_in1, m1);
    chk("issue_in2", bus.o_alu_in2, m2);
    chk("issue_busy_rdy", {bus.o_busy, bus.o_req_ready}, 2'b10);
    step();
    chk("settle_op", bus.o_alu_op, 0);
    chk("settle_in1", bus.o_alu_in1, m1);
    step();
    chk("capture_valid", bus.o_rsp_valid, 0);
    if (stall > 0) bus.i_rsp_ready = 1'b0;
    step();
    chk("resp_valid", bus.o_rsp_valid, 1);
    sd = bus.o_rsp_data;
    sz = bus.o_rsp_z;
    for (int i = 0; i < stall; i++) begin
      bus.i_req_valid = 1'b1;
      bus.i_req_op    = nop;
      bus.i_req_a     = na;
      bus.i_req_b     = nb;
      step();
      chk("stall_valid", bus.o_rsp_valid, 1);
      chk("stall_data", bus.o_rsp_data, sd);
      chk("stall_z", bus.o_rsp_z, sz);
      chk("stall_rdy", bus.o_req_ready, 0);
      chk("stall_op", bus.o_alu_op, 0);
    end
    bus.i_rsp_ready = 1'b1;
    step();
    chk("done_valid", bus.o_rsp_valid, 0);
    chk("done_rdy", bus.o_req_ready, 1);
    chk("done_busy", bus.o_busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req_valid = 1'b0;
    bus.i_req_op    = 2'd0;
    bus.i_req_a     = 16'h0;
    bus.i_req_b     = 16'h0;
    bus.i_rsp_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    check_reset_vals("rst");
    step();
    rst = 1'b0;
    step();
    check_reset_vals("post_rst");

    run_op(2'd1, 16'h0003, 16'h0004, 0, 2'd0, 16'h0, 16'h0);
    run_op(2'd2, 16'h0005, 16'h0005, 0, 2'd0, 16'h0, 16'h0);
    run_op(2'd2, 16'h0002, 16'h0005, 0, 2'd0, 16'h0, 16'h0);
    run_op(2'd3, 16'h0100, 16'h0100, 0, 2'd0, 16'h0, 16'h0);
    run_op(2'd1, 16'hFFFF, 16'h0001, 0, 2'd0, 16'h0, 16'h0);
    run_op(2'd3, 16'h0007, 16'h0009, 0, 2'd0, 16'h0, 16'h0);
    run_op(2'd0, 16'hAAAA, 16'h5555, 0, 2'd0, 16'h0, 16'h0);
    run_op(2'd1, 16'h1234, 16'h1111, 6, 2'd3, 16'h0003, 16'h0005);
    run_op(2'd3, 16'h0003, 16'h0005, 0, 2'd0, 16'h0, 16'h0);

    // abort in SETTLE: ALU has already taken the SUB
    bus.i_req_valid = 1'b1;
    bus.i_req_op    = 2'd2;
    bus.i_req_a     = 16'h0009;
    bus.i_req_b     = 16'h0004;
    wait_ready();
    step();
    bus.i_req_valid = 1'b0;
    step();
    chk("abort_in_settle_busy", bus.o_busy, 1);
    #2 rst = 1'b1;
    #1;
    check_reset_vals("abort");
    step();
    rst = 1'b0;
    held = 16'h0005;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_no_rsp", bus.o_rsp_valid, 0);
    end
    run_op(2'd0, 16'h0, 16'h0, 0, 2'd0, 16'h0, 16'h0);

    step();
    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
